adc_capture_seq: RTL and testbench

Capture sequencer for the 8-bit parallel ADC sampling path. It generates the ADC conversion clock and latches one sample per conversion period. On command it arms an optional level trigger, then writes a programmed number of samples into an internal FIFO. A downstream reader (SPI/GPIO bridge) drains the FIFO through a valid/ready handshake. It sits between the external ADC pins and the readout logic, and replaces the free-running sampler with a start/trigger/count-controlled one.

---
 rtl/adc_capture_seq.sv | 169 ++++++++++++++++
 tb/tb_adc_capture_seq.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_capture_seq.sv
// adc_capture_seq: ADC clock generator, sample latch, start/trigger/count
// capture sequencer and first-word-fall-through sample FIFO.
module adc_capture_seq #(
  parameter int CLK_DIV = 4,
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [15:0] i_count,
  input  logic        i_trig_en,
  input  logic [7:0]  i_trig_level,
  output logic        o_adc_clk,
  input  logic [7:0]  i_adc_data,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_overrun,
  output logic        o_rd_valid,
  output logic [7:0]  o_rd_data,
  input  logic        i_rd_ready
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_CAPTURE} state_t;

  logic [DIV_W-1:0]  div_q;
  logic [DIV_W-1:0]  div_d;
  logic              adc_clk_q;
  logic              strobe;
  logic [7:0]        smp_q;
  logic              smp_vld_q;

  state_t            state_q;
  logic [15:0]       cnt_q;
  logic              trig_en_q;
  logic [7:0]        level_q;
  logic [7:0]        prev_q;
  logic              prev_vld_q;
  logic              busy_q;
  logic              done_q;
  logic              overrun_q;

  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W:0]   wr_ptr_q;
  logic [ADDR_W:0]   rd_ptr_q;
  logic              empty;
  logic              full;
  logic              rd_fire;
  logic              trig_hit;
  logic              capture;
  logic              wr_en;

  assign div_d  = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
  // The strobe sits one i_clk after the ADC clock falls, when its output is stable.
  assign strobe = (div_q == DIV_HALF);

  // Free-running divider; the ADC clock is registered from the next divider value
  // so it is high exactly while div is in the lower half of the period.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      div_q     <= '0;
      adc_clk_q <= 1'b1;
    end else begin
      div_q     <= div_d;
      adc_clk_q <= (div_d < DIV_HALF);
    end
  end

  // Latch the ADC bus on the strobe; smp_vld marks the cycle the sample is usable.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      smp_q     <= '0;
      smp_vld_q <= 1'b0;
    end else begin
      smp_vld_q <= strobe;
      if (strobe) smp_q <= i_adc_data;
    end
  end

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                    (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
  assign rd_fire  = !empty && i_rd_ready;
  // The first sample after arming has prev_vld low, so it can never trigger.
  assign trig_hit = prev_vld_q && (prev_q < level_q) && (smp_q >= level_q);
  assign capture  = smp_vld_q &&
                    ((state_q == S_CAPTURE) ||
                     ((state_q == S_ARM) && (!trig_en_q || trig_hit)));
  // A read in the same cycle frees a slot, so a full FIFO still accepts the write.
  assign wr_en    = capture && (!full || rd_fire);

  // Sequencer: arm on start, optionally wait for a rising level crossing, then count samples.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
      prev_vld_q <= 1'b0;
      cnt_q      <= '0;
      trig_en_q  <= 1'b0;
      level_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_start && (i_count != 16'd0)) begin
            state_q    <= S_ARM;
            busy_q     <= 1'b1;
            cnt_q      <= i_count;
            trig_en_q  <= i_trig_en;
            level_q    <= i_trig_level;
            overrun_q  <= 1'b0;
            prev_vld_q <= 1'b0;
          end
        end
        S_ARM, S_CAPTURE: begin
          if ((state_q == S_ARM) && smp_vld_q) begin
            prev_q     <= smp_q;
            prev_vld_q <= 1'b1;
          end
          if (capture) begin
            if (!wr_en) overrun_q <= 1'b1;
            cnt_q <= cnt_q - 16'd1;
            if (cnt_q == 16'd1) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_CAPTURE;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // FIFO pointers with a wrap bit to tell full from empty.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en)   wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_fire) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // FIFO storage; contents are only meaningful between the pointers.
  always_ff @(posedge i_clk) begin
    if (wr_en) mem_q[wr_ptr_q[ADDR_W-1:0]] <= smp_q;
  end

  assign o_adc_clk  = adc_clk_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_overrun  = overrun_q;
  assign o_rd_valid = !empty;
  assign o_rd_data  = empty ? 8'h00 : mem_q[rd_ptr_q[ADDR_W-1:0]];

endmodule

// File: tb/tb_adc_capture_seq.sv
// Testbench for adc_capture_seq: directed scenarios plus randomized captures,
// every cycle compared against a queue-based behavioural model.
module tb_adc_capture_seq;

  localparam int CLK_DIV = 4;
  localparam int DEPTH   = 16;
  localparam int ADDR_W  = 4;
  localparam int M_IDLE  = 0;
  localparam int M_ARM   = 1;
  localparam int M_CAP   = 2;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_start = 1'b0;
  logic [15:0] i_count = '0;
  logic        i_trig_en = 1'b0;
  logic [7:0]  i_trig_level = '0;
  logic        o_adc_clk;
  logic [7:0]  i_adc_data = '0;
  logic        o_busy;
  logic        o_done;
  logic        o_overrun;
  logic        o_rd_valid;
  logic [7:0]  o_rd_data;
  logic        i_rd_ready = 1'b0;

  adc_capture_seq #(.CLK_DIV(CLK_DIV), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_count(i_count),
    .i_trig_en(i_trig_en), .i_trig_level(i_trig_level), .o_adc_clk(o_adc_clk),
    .i_adc_data(i_adc_data), .o_busy(o_busy), .o_done(o_done), .o_overrun(o_overrun),
    .o_rd_valid(o_rd_valid), .o_rd_data(o_rd_data), .i_rd_ready(i_rd_ready)
  );

  always #5 i_clk = ~i_clk;

  int n_pass = 0;
  int n_total = 0;

  // Behavioural model state
  int         m_div = 0;
  int         m_mode = M_IDLE;
  int         m_rem = 0;
  bit         m_ten = 0;
  logic [7:0] m_lvl = '0;
  logic [7:0] m_prev = '0;
  bit         m_prevv = 0;
  bit         m_ovr = 0;
  bit         m_done = 0;
  bit         m_pv = 0;
  logic [7:0] m_ps = '0;
  logic [7:0] q[$];

  // Bench bookkeeping
  logic [7:0] adc_seq[$];
  logic [7:0] got[$];
  int done_cnt = 0;
  int busy_cyc = 0;
  int cyc = 0;
  int last_rise = -1;
  logic last_clk = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One clock edge of the specified behaviour, applied to the inputs present now.
  function automatic void model_step();
    bit cap;
    m_done = 0;
    if (i_rst) begin
      m_div = 0; m_mode = M_IDLE; m_ovr = 0; m_pv = 0; m_ps = '0; m_prevv = 0;
      q.delete();
      return;
    end
    if (q.size() > 0 && i_rd_ready) void'(q.pop_front());
    if (m_mode == M_IDLE) begin
      if (i_start && i_count != 16'd0) begin
        m_mode = M_ARM; m_rem = int'(i_count); m_ten = i_trig_en; m_lvl = i_trig_level;
        m_ovr = 0; m_prevv = 0;
      end
    end else if (m_pv) begin
      cap = (m_mode == M_CAP) || !m_ten || (m_prevv && m_prev < m_lvl && m_ps >= m_lvl);
      if (m_mode == M_ARM) begin m_prev = m_ps; m_prevv = 1; end
      if (cap) begin
        m_mode = M_CAP;
        if (q.size() < DEPTH) q.push_back(m_ps);
        else m_ovr = 1;
        m_rem--;
        if (m_rem == 0) begin m_mode = M_IDLE; m_done = 1; end
      end
    end
    m_pv = (m_div == CLK_DIV / 2);
    m_ps = i_adc_data;
    m_div = (m_div + 1) % CLK_DIV;
  endfunction

  task automatic tick();
    if (m_div == CLK_DIV / 2 && adc_seq.size() > 0) i_adc_data = adc_seq.pop_front();
    else i_adc_data = 8'($urandom);
    if (o_rd_valid === 1'b1 && i_rd_ready) got.push_back(o_rd_data);
    model_step();
    @(posedge i_clk);
    #1;
    cyc++;
    if (i_rst) last_rise = -1;
    else if (o_adc_clk && !last_clk) begin
      if (last_rise >= 0) check("adc_clk_period", cyc - last_rise, CLK_DIV);
      last_rise = cyc;
    end
    last_clk = o_adc_clk;
    if (o_done) done_cnt++;
    if (o_busy) busy_cyc++;
    check("adc_clk", o_adc_clk, (m_div < CLK_DIV / 2));
    check("busy", o_busy, (m_mode != M_IDLE));
    check("done", o_done, m_done);
    check("overrun", o_overrun, m_ovr);
    check("rd_valid", o_rd_valid, (q.size() > 0));
    if (q.size() > 0) check("rd_data", o_rd_data, q[0]);
  endtask

  // Bring the divider to its last phase so the next start lands at a known offset.
  task automatic align();
    while (m_div != CLK_DIV - 1) tick();
  endtask

  task automatic pulse_start(input int cnt, input bit ten, input logic [7:0] lvl);
    i_start = 1'b1; i_count = 16'(cnt); i_trig_en = ten; i_trig_level = lvl;
    tick();
    i_start = 1'b0; i_count = '0; i_trig_en = 1'b0; i_trig_level = '0;
  endtask

  task automatic run_until_done(input int budget);
    int n = 0;
    bit seen = 0;
    while (!seen && n < budget) begin
      tick();
      n++;
      if (o_done) seen = 1;
    end
    check("done_within_budget", seen, 1'b1);
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    check("rst_adc_clk", o_adc_clk, 1'b1);
    check("rst_busy", o_busy, 1'b0);
    check("rst_done", o_done, 1'b0);
    check("rst_overrun", o_overrun, 1'b0);
    check("rst_rd_valid", o_rd_valid, 1'b0);
    check("rst_rd_data", o_rd_data, 8'h00);
    i_rst = 1'b0;
    repeat (2) tick();

    // Zero-count start is ignored
    pulse_start(0, 1'b0, 8'h00);
    check("zero_count_busy", o_busy, 1'b0);
    tick();
    check("zero_count_busy_later", o_busy, 1'b0);

    // Basic capture: ramp, reader always ready
    i_rd_ready = 1'b1;
    align();
    for (int i = 0; i < 16; i++) adc_seq.push_back(8'(8'h10 + i));
    got.delete(); done_cnt = 0; busy_cyc = 0;
    pulse_start(5, 1'b0, 8'h00);
    run_until_done(10 * CLK_DIV);
    repeat (3) tick();
    adc_seq.delete();
    check("basic_count", got.size(), 5);
    for (int i = 0; i < 5 && i < got.size(); i++) check("basic_data", got[i], 8'(8'h10 + i));
    check("basic_done_pulses", done_cnt, 1);
    check("basic_busy_span", busy_cyc, 5 * CLK_DIV);

    // Level trigger, reader stalled
    i_rd_ready = 1'b0;
    align();
    adc_seq = '{8'h90, 8'h70, 8'h7F, 8'h80, 8'h81};
    pulse_start(2, 1'b1, 8'h80);
    run_until_done(10 * CLK_DIV);
    check("trig_valid", o_rd_valid, 1'b1);
    check("trig_first", o_rd_data, 8'h80);
    i_rd_ready = 1'b1; tick(); i_rd_ready = 1'b0;
    check("trig_second", o_rd_data, 8'h81);
    i_rd_ready = 1'b1; tick(); i_rd_ready = 1'b0;
    check("trig_empty", o_rd_valid, 1'b0);

    // Overrun: 20 samples into a 16-deep FIFO with no reader
    align();
    for (int i = 0; i < 20; i++) adc_seq.push_back(8'(8'h20 + i));
    done_cnt = 0;
    pulse_start(20, 1'b0, 8'h00);
    run_until_done(24 * CLK_DIV);
    check("ovr_flag", o_overrun, 1'b1);
    check("ovr_done_pulses", done_cnt, 1);

    // New start clears overrun; write into full FIFO while reading
    align();
    adc_seq = '{8'h55};
    got.delete();
    pulse_start(1, 1'b0, 8'h00);
    check("ovr_cleared", o_overrun, 1'b0);
    repeat (CLK_DIV - 1) tick();
    i_rd_ready = 1'b1; tick(); i_rd_ready = 1'b0;
    check("full_rw_done", o_done, 1'b1);
    check("full_rw_no_overrun", o_overrun, 1'b0);
    i_rd_ready = 1'b1;
    for (int n = 0; n < 40 && o_rd_valid; n++) tick();
    check("full_rw_entries", got.size(), 17);
    for (int i = 0; i < 16 && i < got.size(); i++) check("full_rw_order", got[i], 8'(8'h20 + i));
    if (got.size() == 17) check("full_rw_last", got[16], 8'h55);

    // Start during capture is ignored
    align();
    for (int i = 0; i < 8; i++) adc_seq.push_back(8'(8'h40 + i));
    got.delete(); done_cnt = 0;
    pulse_start(3, 1'b0, 8'h00);
    repeat (6) tick();
    pulse_start(9, 1'b1, 8'hFF);
    run_until_done(10 * CLK_DIV);
    repeat (3) tick();
    adc_seq.delete();
    check("busy_start_count", got.size(), 3);
    for (int i = 0; i < 3 && i < got.size(); i++) check("busy_start_data", got[i], 8'(8'h40 + i));
    check("busy_start_done", done_cnt, 1);

    // Reset mid-capture
    i_rd_ready = 1'b0;
    align();
    pulse_start(10, 1'b0, 8'h00);
    for (int n = 0; n < 20 * CLK_DIV && m_rem != 7; n++) tick();
    check("mid_rst_progress", o_rd_valid, 1'b1);
    done_cnt = 0;
    i_rst = 1'b1; tick(); i_rst = 1'b0;
    check("mid_rst_busy", o_busy, 1'b0);
    check("mid_rst_rd_valid", o_rd_valid, 1'b0);
    check("mid_rst_done", o_done, 1'b0);
    repeat (8) tick();
    check("mid_rst_no_done", done_cnt, 0);
    i_rd_ready = 1'b1;
    align();
    adc_seq = '{8'h70, 8'h71};
    got.delete();
    pulse_start(2, 1'b0, 8'h00);
    run_until_done(6 * CLK_DIV);
    repeat (3) tick();
    check("post_rst_count", got.size(), 2);
    if (got.size() == 2) begin
      check("post_rst_d0", got[0], 8'h70);
      check("post_rst_d1", got[1], 8'h71);
    end

    // Randomized captures at arbitrary phases
    for (int k = 0; k < 10; k++) begin
      int waitn;
      waitn = $urandom_range(0, 5);
      for (int n = 0; n < waitn; n++) begin i_rd_ready = 1'($urandom); tick(); end
      pulse_start($urandom_range(1, 24), 1'($urandom), 8'($urandom_range(8'h20, 8'hE0)));
      for (int n = 0; n < 4000 && m_mode != M_IDLE; n++) begin
        i_rd_ready = 1'($urandom);
        i_start = ($urandom_range(0, 9) == 0);
        i_count = 16'($urandom);
        tick();
        i_start = 1'b0;
      end
      check("rand_capture_finished", o_busy, 1'b0);
    end
    i_rd_ready = 1'b1;
    for (int n = 0; n < 40 && o_rd_valid; n++) tick();
    check("final_drained", o_rd_valid, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
